// File: rtl/parking.sv
// rtl/parking.sv - two-category car park occupancy tracker
//
// Counts cars in university-reserved and general spaces, refusing entries into
// a full category and exits from an empty one. All outputs are decoded from the
// two registered counters only, so nothing reaches the outputs combinationally
// from the inputs.
//
// Ports:
//   clk                 system clock, rising edge
//   start               synchronous active-high reset, empties the lot
//   car_entered         one car enters this cycle
//   is_uni_car_entered  entry category: 1 = university, 0 = general
//   car_exited          one car leaves this cycle
//   is_uni_car_exited   exit category: 1 = university, 0 = general
//   uni_parked_car      university cars parked
//   parked_care         general cars parked
//   uni_vacated_space   free university spaces
//   vacated_space       free general spaces
//   uni_is_vacated_space  university space available
//   is_vacated_space      general space available

module parking #(
    parameter int UNI_CAPACITY = 500,
    parameter int GEN_CAPACITY = 200
) (
    input  logic       clk,
    input  logic       start,
    input  logic       car_entered,
    input  logic       is_uni_car_entered,
    input  logic       car_exited,
    input  logic       is_uni_car_exited,
    output logic [8:0] uni_parked_car,
    output logic [8:0] parked_care,
    output logic [8:0] uni_vacated_space,
    output logic [8:0] vacated_space,
    output logic       uni_is_vacated_space,
    output logic       is_vacated_space
);

    localparam logic [8:0] UNI_CAP = 9'(UNI_CAPACITY);
    localparam logic [8:0] GEN_CAP = 9'(GEN_CAPACITY);

    logic [8:0] uni_cnt;
    logic [8:0] gen_cnt;
    logic [8:0] uni_after_exit;
    logic [8:0] gen_after_exit;
    logic [8:0] uni_next;
    logic [8:0] gen_next;

    logic uni_entry;
    logic gen_entry;
    logic uni_exit;
    logic gen_exit;

    assign uni_entry = car_entered &  is_uni_car_entered;
    assign gen_entry = car_entered & ~is_uni_car_entered;
    assign uni_exit  = car_exited  &  is_uni_car_exited;
    assign gen_exit  = car_exited  & ~is_uni_car_exited;

    // The exit is applied before the entry is checked, so a full category
    // with a simultaneous exit and entry stays full, and an empty one with
    // both ends up at one.
    always_comb begin
        uni_after_exit = uni_cnt;
        gen_after_exit = gen_cnt;
        if (uni_exit && (uni_cnt != 9'd0)) begin
            uni_after_exit = uni_cnt - 9'd1;
        end
        if (gen_exit && (gen_cnt != 9'd0)) begin
            gen_after_exit = gen_cnt - 9'd1;
        end

        uni_next = uni_after_exit;
        gen_next = gen_after_exit;
        if (uni_entry && (uni_after_exit < UNI_CAP)) begin
            uni_next = uni_after_exit + 9'd1;
        end
        if (gen_entry && (gen_after_exit < GEN_CAP)) begin
            gen_next = gen_after_exit + 9'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            uni_cnt <= 9'd0;
            gen_cnt <= 9'd0;
        end else begin
            uni_cnt <= uni_next;
            gen_cnt <= gen_next;
        end
    end

    assign uni_parked_car       = uni_cnt;
    assign parked_care          = gen_cnt;
    assign uni_vacated_space    = UNI_CAP - uni_cnt;
    assign vacated_space        = GEN_CAP - gen_cnt;
    assign uni_is_vacated_space = (uni_cnt != UNI_CAP);
    assign is_vacated_space     = (gen_cnt != GEN_CAP);

endmodule

// File: tb/tb_parking.sv
// tb/tb_parking.sv - scoreboard bench for parking

module tb_parking;

    localparam int UNI_CAP = 500;
    localparam int GEN_CAP = 200;

    logic       clk = 1'b0;
    logic       start;
    logic       car_entered;
    logic       is_uni_car_entered;
    logic       car_exited;
    logic       is_uni_car_exited;
    logic [8:0] uni_parked_car;
    logic [8:0] parked_care;
    logic [8:0] uni_vacated_space;
    logic [8:0] vacated_space;
    logic       uni_is_vacated_space;
    logic       is_vacated_space;

    always #5 clk = ~clk;

    parking #(
        .UNI_CAPACITY(UNI_CAP),
        .GEN_CAPACITY(GEN_CAP)
    ) dut (
        .clk                 (clk),
        .start               (start),
        .car_entered         (car_entered),
        .is_uni_car_entered  (is_uni_car_entered),
        .car_exited          (car_exited),
        .is_uni_car_exited   (is_uni_car_exited),
        .uni_parked_car      (uni_parked_car),
        .parked_care         (parked_care),
        .uni_vacated_space   (uni_vacated_space),
        .vacated_space       (vacated_space),
        .uni_is_vacated_space(uni_is_vacated_space),
        .is_vacated_space    (is_vacated_space)
    );

    typedef struct {
        int    uni;
        int    gen;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   m_uni = 0;
    int   m_gen = 0;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input int expv);
        total++;
        if (got !== 32'(expv)) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, expv);
        end
    endtask

    task automatic compare_outputs();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 1);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".uni_parked"}, 32'(uni_parked_car), e.uni);
            check({e.tag, ".gen_parked"}, 32'(parked_care), e.gen);
            check({e.tag, ".uni_free"}, 32'(uni_vacated_space), UNI_CAP - e.uni);
            check({e.tag, ".gen_free"}, 32'(vacated_space), GEN_CAP - e.gen);
            check({e.tag, ".uni_flag"}, 32'(uni_is_vacated_space), int'(e.uni != UNI_CAP));
            check({e.tag, ".gen_flag"}, 32'(is_vacated_space), int'(e.gen != GEN_CAP));
        end
    endtask

    // Drive one cycle of stimulus, predict the result, then compare after the edge.
    task automatic step(input logic s, input logic ce, input logic iue,
                        input logic cx, input logic iux, input string tag);
        exp_t e;
        @(negedge clk);
        start              = s;
        car_entered        = ce;
        is_uni_car_entered = iue;
        car_exited         = cx;
        is_uni_car_exited  = iux;
        if (s) begin
            m_uni = 0;
            m_gen = 0;
        end else begin
            if (cx && iux && m_uni > 0) m_uni--;
            if (cx && !iux && m_gen > 0) m_gen--;
            if (ce && iue && m_uni < UNI_CAP) m_uni++;
            if (ce && !iue && m_gen < GEN_CAP) m_gen++;
        end
        e.uni = m_uni;
        e.gen = m_gen;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    initial begin
        start              = 1'b1;
        car_entered        = 1'b0;
        is_uni_car_entered = 1'b0;
        car_exited         = 1'b0;
        is_uni_car_exited  = 1'b0;

        step(1, 0, 0, 0, 0, "reset0");
        step(1, 1, 1, 0, 0, "reset1");
        step(0, 0, 0, 0, 0, "idle");

        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, "uni_in");
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, "gen_in");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, "uni_out");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, "gen_out");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, "uni_out_empty");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, "gen_out_empty");

        for (int i = 0; i < GEN_CAP; i++) step(0, 1, 0, 0, 0, "gen_fill");
        step(0, 1, 0, 0, 0, "gen_over");
        step(0, 1, 0, 1, 0, "gen_full_inout");

        for (int i = 0; i < GEN_CAP - 10; i++) step(0, 0, 0, 1, 0, "gen_drain");
        step(0, 1, 1, 1, 0, "uni_in_gen_out");
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0, "gen_to7");
        step(0, 1, 0, 1, 0, "gen_inout_7");
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0, "gen_to0");
        step(0, 1, 0, 1, 0, "gen_inout_0");

        for (int i = 0; i < UNI_CAP; i++) step(0, 1, 1, 0, 0, "uni_fill");
        step(0, 1, 1, 0, 0, "uni_over");
        step(0, 1, 1, 1, 1, "uni_full_inout");
        step(0, 1, 0, 1, 1, "uni_out_gen_in");

        step(1, 1, 0, 0, 0, "mid_reset");
        step(0, 0, 0, 0, 0, "post_reset");

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), "random");
        end

        @(negedge clk);
        car_entered = 1'b0;
        car_exited  = 1'b0;
        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
